// File: rtl/dsm_sense_ctrl_pkg.sv
// dsm_sense_pkg: state encoding, default constants and result width shared by the sense controller
package dsm_sense_pkg;
    localparam int RES_W = 10;
    localparam int PH_W = 10;
    localparam int WINDOW_DEF = 512;
    localparam int TRIM_DEFAULT_DEF = 147;
    typedef enum logic [1:0] {IDLE, SETTLE, INTEG, HOLD} state_e;
endpackage

// File: rtl/dsm_sense_ctrl_if.sv
// dsm_sense_ctrl_if: host-side request and result handshake of the sense controller
interface dsm_sense_ctrl_if;
    import dsm_sense_pkg::*;
    logic start;
    logic [7:0] trim_code;
    logic [RES_W-1:0] threshold;
    logic result_ready;
    logic busy;
    logic [RES_W-1:0] result;
    logic result_valid;
    logic cell_state;
    modport master (
        output start, trim_code, threshold, result_ready,
        input  busy, result, result_valid, cell_state
    );
    modport slave (
        input  start, trim_code, threshold, result_ready,
        output busy, result, result_valid, cell_state
    );
endinterface

// File: rtl/dsm_ones_counter.sv
// dsm_ones_counter: counts modulator ones, count_o already includes this cycle's bit and saturates
module dsm_ones_counter
    import dsm_sense_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [RES_W-1:0] count_o
);
    logic [RES_W:0] acc_q, acc_d;
    always_comb begin
        acc_d = clear_i ? '0 : acc_q + {{RES_W{1'b0}}, en_i & bit_i};
        count_o = acc_d[RES_W] ? '1 : acc_d[RES_W-1:0];
    end
    always_ff @(posedge clk) begin
        acc_q <= rst ? '0 : acc_d;
    end
endmodule

// File: rtl/dsm_sense_ctrl.sv
// dsm_sense_ctrl: sequences trim/row setup, DSM integration and result handshake.
// Defining DSM_SENSE_MARGIN_EN adds the threshold comparator driving cell_state.
module dsm_sense_ctrl
    import dsm_sense_pkg::*;
#(
    parameter int WINDOW       = WINDOW_DEF,
    parameter int SETTLE_CYC   = 6,
    parameter int TRIM_DEFAULT = TRIM_DEFAULT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    dsm_sense_ctrl_if.slave  bus,
    input  logic             dsm_bit_i,
    output logic [7:0]       chrg_trim_o,
    output logic             row_sel_o,
    output logic             dsm_en_o
);
    state_e state_q, state_d;
    logic [PH_W-1:0] cnt_q, cnt_d;
    logic [7:0] trim_q, trim_d;
    logic [RES_W-1:0] res_q, res_d, count;
    logic cell_q, cell_d;
    dsm_ones_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == IDLE && bus.start),
        .en_i    (state_q == INTEG),
        .bit_i   (dsm_bit_i),
        .count_o (count)
    );
    always_comb begin
        state_d = state_q;
        trim_d = trim_q;
        res_d = res_q;
        cell_d = cell_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SETTLE;
                trim_d = bus.trim_code;
            end
            SETTLE: if (cnt_q == PH_W'(SETTLE_CYC - 1)) state_d = INTEG;
            INTEG: if (cnt_q == PH_W'(WINDOW - 1)) begin
                state_d = HOLD;
                res_d = count;
`ifdef DSM_SENSE_MARGIN_EN
                cell_d = count < bus.threshold;
`endif
            end
            HOLD: if (bus.result_ready) begin
                state_d = IDLE;
                trim_d = 8'(TRIM_DEFAULT);
            end
            default: state_d = IDLE;
        endcase
        // phase counter restarts at 0 on every state change
        cnt_d = (state_d == state_q && (state_q == SETTLE || state_q == INTEG)) ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            trim_q <= 8'(TRIM_DEFAULT);
            res_q <= '0;
            cell_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            trim_q <= trim_d;
            res_q <= res_d;
            cell_q <= cell_d;
        end
    end
    assign chrg_trim_o = trim_q;
    assign row_sel_o = state_q == SETTLE || state_q == INTEG;
    assign dsm_en_o = state_q == INTEG;
    assign bus.busy = state_q != IDLE;
    assign bus.result = res_q;
    assign bus.result_valid = state_q == HOLD;
    assign bus.cell_state = cell_q;
endmodule

// File: tb/tb_dsm_sense_ctrl.sv
// tb_dsm_sense_ctrl: directed vector table plus reset and ignored-start sequences for dsm_sense_ctrl
module tb_dsm_sense_ctrl;
    import dsm_sense_pkg::*;
    typedef struct {
        int         pat;
        logic [7:0] trim;
        logic [9:0] thr;
        logic [9:0] res;
    } vec_t;
    localparam int RST_OUTS = 147 << 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dsm_bit = 1'b1;
    logic [7:0] chrg_trim;
    logic row_sel, dsm_en;
    int n_chk = 0;
    int n_err = 0;
    vec_t vt[5];
    dsm_sense_ctrl_if bif();
    dsm_sense_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bif),
        .dsm_bit_i   (dsm_bit),
        .chrg_trim_o (chrg_trim),
        .row_sel_o   (row_sel),
        .dsm_en_o    (dsm_en)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic int outs();
        return int'({chrg_trim, row_sel, dsm_en, bif.busy, bif.result, bif.result_valid, bif.cell_state});
    endfunction
    function automatic logic pat_bit(input int pat, input int k);
        return pat == 0 ? 1'b1 : pat == 1 ? (k % 2 == 0) : pat == 2 ? (k < 200) : pat == 3 ? (k < 400) : 1'b0;
    endfunction
    task automatic run_sense(input int pat, input logic [7:0] trim, input logic [9:0] thr, input int poke,
                             output int lat, output int en_first, output int en_cnt, output int trim_ok);
        int k;
        k = 0;
        lat = -1;
        en_first = -1;
        en_cnt = 0;
        trim_ok = 1;
        bif.trim_code = trim;
        bif.threshold = thr;
        bif.start = 1'b1;
        for (int c = 1; c <= 1000 && lat < 0; c++) begin
            step();
            bif.start = 1'b0;
            bif.trim_code = ~trim;
            if (bif.result_valid) lat = c;
            else if (!(chrg_trim == trim && row_sel && bif.busy)) trim_ok = 0;
            if (dsm_en) begin
                if (en_first < 0) en_first = c;
                dsm_bit = pat_bit(pat, k);
                k++;
                en_cnt++;
                if (en_cnt == poke) bif.start = 1'b1;
            end else dsm_bit = 1'b1;
        end
    endtask
    initial begin
        int lat, en_first, en_cnt, trim_ok, exp_cell, seen, stable;
        logic [9:0] held;
        vt[0] = '{0, 8'd147, 10'd600, 10'd512};
        vt[1] = '{1, 8'h5A, 10'd100, 10'd256};
        vt[2] = '{2, 8'hFF, 10'd300, 10'd200};
        vt[3] = '{3, 8'h01, 10'd300, 10'd400};
        vt[4] = '{4, 8'h33, 10'd1, 10'd0};
        bif.start = 1'b0;
        bif.trim_code = 8'h00;
        bif.threshold = 10'd0;
        bif.result_ready = 1'b1;
        repeat (3) step();
        chk("reset_outputs", outs(), RST_OUTS);
        rst = 1'b0;
        step();
        chk("idle_after_reset", outs(), RST_OUTS);
        for (int i = 0; i < 5; i++) begin
            run_sense(vt[i].pat, vt[i].trim, vt[i].thr, -1, lat, en_first, en_cnt, trim_ok);
            chk("latency", lat, 519);
            chk("en_first", en_first, 7);
            chk("en_cycles", en_cnt, 512);
            chk("trim_row_busy_during_sense", trim_ok, 1);
            chk("result", int'(bif.result), int'(vt[i].res));
`ifdef DSM_SENSE_MARGIN_EN
            exp_cell = int'(vt[i].res < vt[i].thr);
`else
            exp_cell = 0;
`endif
            chk("cell_state", int'(bif.cell_state), exp_cell);
            chk("hold_outputs", int'({dsm_en, row_sel, chrg_trim}), int'({2'b00, vt[i].trim}));
            step();
            chk("after_transfer", int'({bif.result_valid, bif.busy, chrg_trim}), int'({2'b00, 8'd147}));
        end
        // reset during SETTLE
        bif.trim_code = 8'h44;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        step();
        chk("in_settle", int'({row_sel, dsm_en, chrg_trim}), int'({2'b10, 8'h44}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_settle", outs(), RST_OUTS);
        // reset at INTEG cycle 100
        bif.result_ready = 1'b0;
        dsm_bit = 1'b1;
        bif.trim_code = 8'h66;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        repeat (106) step();
        chk("integ_active", int'(dsm_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_integ", outs(), RST_OUTS);
        seen = 0;
        repeat (600) begin
            step();
            seen |= int'(bif.result_valid | bif.busy);
        end
        chk("no_valid_after_rst", seen, 0);
        bif.result_ready = 1'b1;
        run_sense(0, 8'd147, 10'd600, -1, lat, en_first, en_cnt, trim_ok);
        chk("post_rst_latency", lat, 519);
        chk("post_rst_result", int'(bif.result), 512);
        step();
        // starts during INTEG and HOLD are ignored, result held while ready is low
        bif.result_ready = 1'b0;
        run_sense(1, 8'hC3, 10'd300, 50, lat, en_first, en_cnt, trim_ok);
        chk("poke_latency", lat, 519);
        chk("poke_en_cycles", en_cnt, 512);
        chk("poke_result", int'(bif.result), 256);
        held = bif.result;
        stable = 1;
        bif.start = 1'b1;
        repeat (20) begin
            step();
            bif.start = 1'b0;
            if (!(bif.result_valid && bif.busy && bif.result == held && chrg_trim == 8'hC3 && !dsm_en)) stable = 0;
        end
        chk("hold_stable", stable, 1);
        bif.result_ready = 1'b1;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        bif.result_ready = 1'b0;
        chk("single_transfer", int'({bif.result_valid, bif.busy, chrg_trim}), int'({2'b00, 8'd147}));
        seen = 0;
        repeat (5) begin
            step();
            seen |= int'(bif.busy | bif.result_valid);
        end
        chk("no_queued_start", seen, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
